// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3_pkg
// Purpose : Shared constants for the LC-3 control sequencer: opcode values,
//           sequencer state encoding and the HALT trap vector.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package lc3_pkg;

   // LC-3 opcodes, IR[15:12]
   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   // Sequencer state encoding (visible on state_out)
   localparam int         STATE_W     = 4;
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_EXECUTE   = 4'd3;
   localparam logic [3:0] S_MEM_RD    = 4'd4;
   localparam logic [3:0] S_MEM_RD2   = 4'd5;
   localparam logic [3:0] S_MEM_WR    = 4'd6;
   localparam logic [3:0] S_WRITEBACK = 4'd7;
   localparam logic [3:0] S_UPDATE_PC = 4'd8;
   localparam logic [3:0] S_HALT      = 4'd9;

   // TRAP vector that stops the machine
   localparam logic [7:0] TRAP_HALT = 8'h25;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/lc3_op_class.sv
`default_nettype none
// ============================================================================
// Module  : lc3_op_class
// Purpose : Combinational opcode classifier used by the sequencer to pick
//           the post-EXECUTE path.
// Ports   : opcode     in  4  IR[15:12]
//           is_alu     out 1  ADD/AND/NOT/LEA (register write, no memory)
//           is_load    out 1  needs a data read (LD/LDR/LDI/STI)
//           is_ind     out 1  indirect access (LDI/STI)
//           is_store   out 1  needs a data write (ST/STR/STI)
//           is_br      out 1  PC-only instruction (BR/JMP/RTI/RES)
//           is_link    out 1  writes R7 (JSR/TRAP)
//           is_illegal out 1  RTI/RES
// Revision: 1.0  initial release
// ============================================================================
module lc3_op_class
   import lc3_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_alu,
   output logic       is_load,
   output logic       is_ind,
   output logic       is_store,
   output logic       is_br,
   output logic       is_link,
   output logic       is_illegal
);

   always_comb begin
      is_alu     = 1'b0;
      is_load    = 1'b0;
      is_ind     = 1'b0;
      is_store   = 1'b0;
      is_br      = 1'b0;
      is_link    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_ADD, OP_AND, OP_NOT, OP_LEA: is_alu = 1'b1;
         OP_JSR, OP_TRAP:                is_link = 1'b1;
         OP_LD, OP_LDR:                  is_load = 1'b1;
         OP_LDI: begin
            is_load = 1'b1;
            is_ind  = 1'b1;
         end
         // STI reads the pointer first, then writes through it
         OP_STI: begin
            is_load  = 1'b1;
            is_ind   = 1'b1;
            is_store = 1'b1;
         end
         OP_ST, OP_STR:                  is_store = 1'b1;
         OP_BR, OP_JMP:                  is_br = 1'b1;
         OP_RTI, OP_RES: begin
            is_br      = 1'b1;
            is_illegal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule : lc3_op_class
`default_nettype wire

// File: rtl/lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : lc3_ctrl_fsm
// Purpose : LC-3 instruction sequencer. Walks each instruction through
//           FETCH, DECODE, EXECUTE, MEM_*, WRITEBACK and UPDATE_PC, latches
//           IR and strobes the datapath stages (Moore outputs).
// Params  : MEM_LAT  memory read latency in cycles (>=1)
//           CNT_W    latency counter width, 2**CNT_W > MEM_LAT
// Ports   : clk, rst_n (async, active-low), run_in, instr_in[15:0]
//           fetch_start, ir_out[15:0], en_fetch, en_decode, en_execute,
//           mem_rd, mem_wr, en_wb, illegal_out, halted, state_out[3:0]
// Revision: 1.0  initial release
// ============================================================================
module lc3_ctrl_fsm
   import lc3_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_in,
   input  logic [15:0] instr_in,
   output logic        fetch_start,
   output logic [15:0] ir_out,
   output logic        en_fetch,
   output logic        en_decode,
   output logic        en_execute,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        en_wb,
   output logic        illegal_out,
   output logic        halted,
   output logic [3:0]  state_out
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [15:0]        r_ir;
   logic               w_cnt_last;
   logic               w_is_alu, w_is_load, w_is_ind, w_is_store;
   logic               w_is_br, w_is_link, w_is_illegal;
   logic               w_trap_halt;

   lc3_op_class u_op_class (
      .opcode     (r_ir[15:12]),
      .is_alu     (w_is_alu),
      .is_load    (w_is_load),
      .is_ind     (w_is_ind),
      .is_store   (w_is_store),
      .is_br      (w_is_br),
      .is_link    (w_is_link),
      .is_illegal (w_is_illegal)
   );

   assign w_cnt_last  = (r_cnt == CNT_W'(MEM_LAT - 1));
   assign w_trap_halt = (r_ir[15:12] == OP_TRAP) && (r_ir[7:0] == TRAP_HALT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latency counter: restarts on every state change, parks at MEM_LAT-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_next != r_state) begin
         r_cnt <= '0;
      end else if (!w_cnt_last) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Instruction register: memory data is valid on the last FETCH cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir <= '0;
      end else if ((r_state == S_FETCH) && w_cnt_last) begin
         r_ir <= instr_in;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (run_in) w_next = S_FETCH;
         S_FETCH:     if (w_cnt_last) w_next = S_DECODE;
         S_DECODE:    w_next = w_trap_halt ? S_HALT : S_EXECUTE;
         S_EXECUTE: begin
            if (w_is_alu || w_is_link) begin
               w_next = S_WRITEBACK;
            end else if (w_is_load) begin
               w_next = S_MEM_RD;
            end else if (w_is_store) begin
               w_next = S_MEM_WR;
            end else if (w_is_br) begin
               w_next = S_UPDATE_PC;
            end else begin
               // The classifier is exhaustive; this arm only keeps the FSM closed
               w_next = S_UPDATE_PC;
            end
         end
         S_MEM_RD: begin
            if (w_cnt_last) begin
               if (w_is_ind && w_is_store) begin
                  w_next = S_MEM_WR;
               end else if (w_is_ind) begin
                  w_next = S_MEM_RD2;
               end else begin
                  w_next = S_WRITEBACK;
               end
            end
         end
         S_MEM_RD2:   if (w_cnt_last) w_next = S_WRITEBACK;
         S_MEM_WR:    w_next = S_UPDATE_PC;
         S_WRITEBACK: w_next = S_UPDATE_PC;
         // run_in is only sampled here and in IDLE, so a drop mid-instruction
         // lets the instruction finish before parking
         S_UPDATE_PC: w_next = run_in ? S_FETCH : S_IDLE;
         S_HALT:      w_next = S_HALT;
         default:     w_next = S_IDLE;
      endcase
   end

   // Moore output decode
   always_comb begin
      fetch_start = 1'b0;
      en_fetch    = 1'b0;
      en_decode   = 1'b0;
      en_execute  = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      en_wb       = 1'b0;
      illegal_out = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_FETCH:     en_fetch = 1'b1;
         S_DECODE: begin
            en_decode   = 1'b1;
            illegal_out = w_is_illegal;
         end
         S_EXECUTE:   en_execute = 1'b1;
         S_MEM_RD,
         S_MEM_RD2:   mem_rd = 1'b1;
         S_MEM_WR:    mem_wr = 1'b1;
         S_WRITEBACK: en_wb = 1'b1;
         S_UPDATE_PC: fetch_start = 1'b1;
         S_HALT:      halted = 1'b1;
         default: ;
      endcase
   end

   assign ir_out    = r_ir;
   assign state_out = r_state;

endmodule : lc3_ctrl_fsm
`default_nettype wire
